de_lugish_exponentiation: RTL and testbench

Iterative fixed-point base-2 exponential unit using the De Lugish (shift-and-add) method: computes y = 2^x for an unsigned fractional input x in [0,1), producing y in [1,2). One shift-add iteration per clock. It sits in the LNS MAC datapath as the log-to-linear converter. It uses a ready/valid handshake on both sides.

---
 rtl/de_lugish_exponentiation_pkg.sv | 44 ++++
 rtl/de_lugish_step.sv | 27 ++
 rtl/de_lugish_exponentiation.sv | 114 +++++++++++
 tb/tb_de_lugish_exponentiation.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/de_lugish_exponentiation_pkg.sv
// Shared parameters, state encoding and the log2(1+2^-i) constant table
// for the De Lugish base-2 exponential unit.
package de_lugish_exponentiation_pkg;

  localparam int X_BITS    = 8;
  localparam int Y_BITS    = 16;
  localparam int ITER      = Y_BITS - 1;
  localparam int W         = 24;
  // The accumulator carries two integer bits so an intermediate product can
  // never wrap before the final saturation stage sees it.
  localparam int A_BITS    = W + 2;
  localparam int I_BITS    = $clog2(ITER + 1);
  localparam int DROP_BITS = W - (Y_BITS - 1);

  localparam logic [A_BITS-1:0] A_ONE = A_BITS'(1) << W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // round(log2(1 + 2^-i) * 2^W) for i = 1..ITER; entry 0 is never selected
  // during an iteration and is kept only so a 4-bit index covers the table.
  localparam logic [W-1:0] L_TABLE [ITER+1] = '{
    24'd0,
    24'd9814042,
    24'd5401057,
    24'd2850868,
    24'd1467383,
    24'd744810,
    24'd375270,
    24'd188362,
    24'd94364,
    24'd47228,
    24'd23626,
    24'd11816,
    24'd5909,
    24'd2954,
    24'd1477,
    24'd739
  };

endpackage

// File: rtl/de_lugish_step.sv
// One combinational shift-and-add iteration: conditionally retire L_i from
// the residual and multiply the accumulator by (1 + 2^-i).
module de_lugish_step
  import de_lugish_exponentiation_pkg::*;
(
  input  logic [W-1:0]      r_i,
  input  logic [A_BITS-1:0] a_i,
  input  logic [I_BITS-1:0] idx_i,
  output logic [W-1:0]      r_o,
  output logic [A_BITS-1:0] a_o
);

  logic [W-1:0] lConst;

  // Compare the residual against L_i and apply the subtract / shift-add pair
  // only when the residual can absorb it, keeping r non-negative throughout.
  always_comb begin
    lConst = L_TABLE[idx_i];
    r_o    = r_i;
    a_o    = a_i;
    if (r_i >= lConst) begin
      r_o = r_i - lConst;
      a_o = a_i + (a_i >> idx_i);
    end
  end

endmodule

// File: rtl/de_lugish_exponentiation.sv
// Iterative y = 2^x converter (U0.8 in, U1.15 out) with ready/valid on both
// sides; one De Lugish iteration per clock, then a rounding/output stage.
module de_lugish_exponentiation
  import de_lugish_exponentiation_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [X_BITS-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_enable,
  output logic [Y_BITS-1:0] data_out,
  output logic              data_out_valid,
  input  logic              data_out_enable
);

  state_t              state_q, state_d;
  logic [W-1:0]        residual_q, residual_d;
  logic [A_BITS-1:0]   accum_q, accum_d;
  logic [I_BITS-1:0]   iterIdx_q, iterIdx_d;
  logic [Y_BITS-1:0]   outData_q, outData_d;
  logic                outValid_q, outValid_d;

  logic [W-1:0]        stepR;
  logic [A_BITS-1:0]   stepA;
  logic [A_BITS:0]     roundSum;
  logic [A_BITS:0]     roundShift;
  logic [Y_BITS-1:0]   roundedOut;

  de_lugish_step u_step (
    .r_i   (residual_q),
    .a_i   (accum_q),
    .idx_i (iterIdx_q),
    .r_o   (stepR),
    .a_o   (stepA)
  );

  // Round the accumulator to 15 fractional bits (half-up) and clamp to
  // all-ones if the rounding would carry into the integer bit above U1.15.
  always_comb begin
    roundSum   = {1'b0, accum_q} + ((A_BITS + 1)'(1) << (DROP_BITS - 1));
    roundShift = roundSum >> DROP_BITS;
    if (|roundShift[A_BITS:Y_BITS]) begin
      roundedOut = '1;
    end else begin
      roundedOut = roundShift[Y_BITS-1:0];
    end
  end

  // Next-state and datapath control. DONE spends its first cycle latching the
  // rounded result, then holds it with valid high until the consumer takes it.
  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    accum_d    = accum_q;
    iterIdx_d  = iterIdx_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    case (state_q)
      IDLE: begin
        if (data_in_valid) begin
          residual_d = {data_in, {(W - X_BITS){1'b0}}};
          accum_d    = A_ONE;
          iterIdx_d  = I_BITS'(1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        residual_d = stepR;
        accum_d    = stepA;
        iterIdx_d  = iterIdx_q + 1'b1;
        if (iterIdx_q == I_BITS'(ITER)) begin
          iterIdx_d = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (!outValid_q) begin
          outData_d  = roundedOut;
          outValid_d = 1'b1;
        end else if (data_out_enable) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any computation in flight.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= IDLE;
      residual_q <= '0;
      accum_q    <= '0;
      iterIdx_q  <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      accum_q    <= accum_d;
      iterIdx_q  <= iterIdx_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

  assign data_in_enable = (state_q == IDLE);
  assign data_out_valid = outValid_q;
  assign data_out       = outData_q;

endmodule

// File: tb/tb_de_lugish_exponentiation.sv
// Directed bench for the De Lugish 2^x unit: reset behaviour, handshake
// timing, known results, backpressure and a full input sweep against 2^x.
module tb_de_lugish_exponentiation;
  import de_lugish_exponentiation_pkg::*;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic [X_BITS-1:0] data_in = '0;
  logic              data_in_valid = 1'b0;
  logic              data_in_enable;
  logic [Y_BITS-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_enable = 1'b0;

  int checks = 0;
  int failures = 0;

  de_lugish_exponentiation dut (
    .clk             (clk),
    .rstn            (rstn),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .data_in_enable  (data_in_enable),
    .data_out        (data_out),
    .data_out_valid  (data_out_valid),
    .data_out_enable (data_out_enable)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkNear(input string tag, input logic [31:0] observed,
                           input int expected, input int tol);
    int diff;
    bit ok;
    ok   = !$isunknown(observed);
    diff = int'(observed) - expected;
    if (diff < 0) diff = -diff;
    ok = ok && (diff <= tol);
    checks++;
    assert (ok === 1'b1) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h+/-%0d", tag, observed, expected, tol);
    end
  endtask

  // Present an operand and return just after the edge that accepted it.
  task automatic applyStimulus(input logic [X_BITS-1:0] x, output logic accepted);
    int guard;
    guard = 0;
    data_in       = x;
    data_in_valid = 1'b1;
    while (data_in_enable !== 1'b1 && guard < 40) begin
      stepCycle();
      guard++;
    end
    accepted = (data_in_enable === 1'b1);
    stepCycle();
    data_in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until the result is flagged valid.
  task automatic waitResult(output int latency);
    latency = 0;
    while (data_out_valid !== 1'b1 && latency < 60) begin
      stepCycle();
      latency++;
    end
  endtask

  // Full transaction with a one-cycle consume pulse; returns the result.
  task automatic runOne(input string tag, input logic [X_BITS-1:0] x,
                        output logic [Y_BITS-1:0] y);
    logic acc;
    int   lat;
    applyStimulus(x, acc);
    checkOutput({tag, "_accept"}, {31'd0, acc}, 32'd1);
    waitResult(lat);
    checkOutput({tag, "_latency"}, lat, 32'd16);
    y = data_out;
    data_out_enable = 1'b1;
    stepCycle();
    data_out_enable = 1'b0;
  endtask

  function automatic int idealResult(input int code);
    real v;
    int  r;
    v = $pow(2.0, real'(code) / 256.0) * 32768.0;
    r = $rtoi(v + 0.5);
    if (r > 65535) r = 65535;
    return r;
  endfunction

  initial begin
    logic              acc;
    int                lat;
    logic [Y_BITS-1:0] y;
    logic [Y_BITS-1:0] held;
    int                prev;

    $display("[TB] start");

    // Reset values while reset is held.
    repeat (3) stepCycle();
    checkOutput("rst_in_enable", {31'd0, data_in_enable}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, data_out_valid}, 32'd0);
    checkOutput("rst_data_out", {16'd0, data_out}, 32'd0);
    rstn = 1'b0;
    stepCycle();

    // Reset in the middle of an iteration run aborts it immediately.
    applyStimulus(8'h80, acc);
    repeat (5) stepCycle();
    rstn = 1'b1;
    #1;
    checkOutput("midbusy_in_enable", {31'd0, data_in_enable}, 32'd1);
    checkOutput("midbusy_out_valid", {31'd0, data_out_valid}, 32'd0);
    stepCycle();
    rstn = 1'b0;
    stepCycle();

    // x = 0.5 with explicit handshake timing checks.
    applyStimulus(8'h80, acc);
    checkOutput("half_accept", {31'd0, acc}, 32'd1);
    checkOutput("half_in_enable_drop", {31'd0, data_in_enable}, 32'd0);
    waitResult(lat);
    checkOutput("half_latency", lat, 32'd16);
    checkNear("half_result", {16'd0, data_out}, 32'hB505, 2);
    checkOutput("half_exclusive", {31'd0, data_in_enable}, 32'd0);
    held = data_out;
    repeat (2) stepCycle();
    checkOutput("half_hold_valid", {31'd0, data_out_valid}, 32'd1);
    data_out_enable = 1'b1;
    stepCycle();
    data_out_enable = 1'b0;
    checkOutput("half_consumed_valid", {31'd0, data_out_valid}, 32'd0);
    checkOutput("half_consumed_in_enable", {31'd0, data_in_enable}, 32'd1);
    checkOutput("half_data_kept", {16'd0, data_out}, {16'd0, held});

    // Further directed values, including the input range ends.
    runOne("quarter", 8'h40, y);
    checkNear("quarter_result", {16'd0, y}, 32'h9838, 2);
    runOne("eighth", 8'h20, y);
    checkNear("eighth_result", {16'd0, y}, 32'h8B96, 2);
    runOne("zero", 8'h00, y);
    checkOutput("zero_result", {16'd0, y}, 32'h8000);
    runOne("max", 8'hFF, y);
    checkNear("max_result", {16'd0, y}, 32'hFF4E, 2);

    // Backpressure: result held while a new operand waits at the input.
    applyStimulus(8'h80, acc);
    waitResult(lat);
    checkOutput("bp_latency", lat, 32'd16);
    held = data_out;
    data_in       = 8'h00;
    data_in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      stepCycle();
      checkOutput("bp_valid", {31'd0, data_out_valid}, 32'd1);
      checkOutput("bp_stable", {16'd0, data_out}, {16'd0, held});
      checkOutput("bp_in_enable", {31'd0, data_in_enable}, 32'd0);
    end
    data_out_enable = 1'b1;
    stepCycle();
    data_out_enable = 1'b0;
    checkOutput("b2b_idle", {31'd0, data_in_enable}, 32'd1);
    stepCycle();
    checkOutput("b2b_accepted", {31'd0, data_in_enable}, 32'd0);
    data_in_valid = 1'b0;
    waitResult(lat);
    checkOutput("b2b_latency", lat, 32'd16);
    checkOutput("b2b_result", {16'd0, data_out}, 32'h8000);
    data_out_enable = 1'b1;
    stepCycle();

    // Sweep every code with the consumer always ready.
    prev = 0;
    for (int code = 0; code < 256; code++) begin
      applyStimulus(X_BITS'(code), acc);
      waitResult(lat);
      checkOutput($sformatf("sweep_latency_%02h", code), lat, 32'd16);
      y = data_out;
      checkNear($sformatf("sweep_%02h", code), {16'd0, y}, idealResult(code), 2);
      checkOutput($sformatf("sweep_monotonic_%02h", code),
                  {31'd0, (int'(y) >= prev)}, 32'd1);
      prev = int'(y);
    end
    stepCycle();
    data_out_enable = 1'b0;
    stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
